// File: rtl/e_bus_handover_ctrl.sv
// Bus ownership handover between the host 68000 and the Pistorm, clocked on E.
// Waits for Pi activity, requests the bus, qualifies BG against an idle bus, falls back on timeout.
`timescale 1ns/1ps
module e_bus_handover_ctrl #(
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned ALIVE_TICKS  = 1418440,
  parameter int unsigned GRANT_TICKS  = 64,
  parameter int unsigned SETTLE_TICKS = 4
) (
  input  logic       e_clock,
  input  logic       rst_pistorm_mode,
  input  logic       pistorm_en,
  input  logic       sys_reset_n,
  input  logic       pi_activity,
  input  logic       m68k_bg_n,
  input  logic       m68k_as_n,
  input  logic       m68k_dtack_n,
  output logic       bus_request,
  output logic       bus_granted,
  output logic       fallback,
  output logic [2:0] state,
  output logic [3:0] timeout_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_ALIVE = 3'd1,
    REQUEST    = 3'd2,
    SETTLE     = 3'd3,
    OWNED      = 3'd4,
    RELEASE    = 3'd5,
    FALLBACK   = 3'd6
  } state_t;

  // A zero tick budget behaves as one tick: the counter is loaded with zero and expires next edge.
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALIVE_LOAD  = (ALIVE_TICKS  == 0) ? '0 : CNT_W'(ALIVE_TICKS - 1);
  localparam logic [CNT_W-1:0] GRANT_LOAD  = (GRANT_TICKS  == 0) ? '0 : CNT_W'(GRANT_TICKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_TICKS == 0) ? '0 : CNT_W'(SETTLE_TICKS - 1);

  localparam int SYNC_N = 6;
  // Bit order {en, sys_reset_n, activity, bg_n, as_n, dtack_n}; reset to the inactive level.
  localparam logic [SYNC_N-1:0] SYNC_INIT = 6'b010111;

  logic [SYNC_N-1:0] async_in;
  logic [SYNC_N-1:0] sync_s;

  assign async_in = {pistorm_en, sys_reset_n, pi_activity, m68k_bg_n, m68k_as_n, m68k_dtack_n};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_N; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge e_clock or posedge rst_pistorm_mode) begin
        if (rst_pistorm_mode) begin
          meta_reg <= SYNC_INIT[gi];
          sync_reg <= SYNC_INIT[gi];
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_s[gi] = sync_reg;
    end
  endgenerate

  logic en_s, sys_reset_s, act_s, bg_s, as_s, dtack_s;
  assign {en_s, sys_reset_s, act_s, bg_s, as_s, dtack_s} = sync_s;

  logic bus_idle, abort, cnt_zero;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_dec;
  logic [3:0] timeout_count_reg, tmo_next;
  state_t state_reg, state_next;
  logic bus_request_reg, bus_granted_reg, fallback_reg;

  assign bus_idle = as_s & dtack_s;
  assign abort    = ~sys_reset_s | ~en_s;
  assign cnt_zero = (cnt_reg == '0);
  assign cnt_dec  = cnt_reg - CNT_ONE;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tmo_next   = timeout_count_reg;
    case (state_reg)
      IDLE: begin
        if (en_s && sys_reset_s) begin
          state_next = WAIT_ALIVE;
          cnt_next   = ALIVE_LOAD;
        end
      end
      WAIT_ALIVE: begin
        if (abort) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end else if (act_s) begin
          state_next = REQUEST;
          cnt_next   = GRANT_LOAD;
        end else if (cnt_zero) begin
          state_next = FALLBACK;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      REQUEST: begin
        if (abort) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end else if (!bg_s && bus_idle) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else if (cnt_zero) begin
          state_next = FALLBACK;
          if (timeout_count_reg != 4'hF) tmo_next = timeout_count_reg + 4'd1;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      SETTLE: begin
        // Any bus activity or loss of grant restarts the idle-bus qualification window.
        if (abort) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end else if (!bus_idle || bg_s) begin
          cnt_next = SETTLE_LOAD;
        end else if (cnt_zero) begin
          state_next = OWNED;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      OWNED: begin
        if (abort) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        // Counter bit 0 records that the previous tick already saw reset released.
        if (!sys_reset_s) cnt_next = '0;
        else if (cnt_reg[0]) state_next = IDLE;
        else cnt_next = CNT_ONE;
      end
      FALLBACK: begin
        if (!sys_reset_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge e_clock or posedge rst_pistorm_mode) begin
    if (rst_pistorm_mode) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      timeout_count_reg <= '0;
      bus_request_reg   <= 1'b0;
      bus_granted_reg   <= 1'b0;
      fallback_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      timeout_count_reg <= tmo_next;
      bus_request_reg   <= (state_next == REQUEST) || (state_next == SETTLE) || (state_next == OWNED);
      bus_granted_reg   <= (state_next == OWNED);
      fallback_reg      <= (state_next == FALLBACK);
    end
  end

  assign state         = state_reg;
  assign timeout_count = timeout_count_reg;
  assign bus_request   = bus_request_reg;
  assign bus_granted   = bus_granted_reg;
  assign fallback      = fallback_reg;

endmodule

// File: tb/tb_e_bus_handover_ctrl.sv
// Scoreboard bench for e_bus_handover_ctrl: stimulus pushes expected outputs from a phase/elapsed-time
// model, a monitor pops one entry per E tick and compares.
`timescale 1ns/1ps
module tb_e_bus_handover_ctrl;
  localparam int unsigned ALIVE  = 8;
  localparam int unsigned GRANT  = 4;
  localparam int unsigned SETTLE = 2;

  logic e_clock = 1'b0;
  logic rst_pistorm_mode = 1'b1;
  logic pistorm_en = 1'b0, sys_reset_n = 1'b0, pi_activity = 1'b0;
  logic m68k_bg_n = 1'b1, m68k_as_n = 1'b1, m68k_dtack_n = 1'b1;
  logic bus_request, bus_granted, fallback;
  logic [2:0] state;
  logic [3:0] timeout_count;

  e_bus_handover_ctrl #(
    .CNT_W(22), .ALIVE_TICKS(ALIVE), .GRANT_TICKS(GRANT), .SETTLE_TICKS(SETTLE)
  ) dut (
    .e_clock(e_clock), .rst_pistorm_mode(rst_pistorm_mode), .pistorm_en(pistorm_en),
    .sys_reset_n(sys_reset_n), .pi_activity(pi_activity), .m68k_bg_n(m68k_bg_n),
    .m68k_as_n(m68k_as_n), .m68k_dtack_n(m68k_dtack_n), .bus_request(bus_request),
    .bus_granted(bus_granted), .fallback(fallback), .state(state), .timeout_count(timeout_count)
  );

  always #5 e_clock = ~e_clock;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       gnt;
    logic       fb;
    logic [3:0] tmo;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: current phase (spec state code), edges elapsed in that phase, timeout tally,
  // and what the FSM can see (inputs lag two edges behind the pins).
  int m_mode = 0, m_ticks = 0, m_tmo = 0;
  logic [5:0] seen_lag0 = 6'b010111, seen_lag1 = 6'b010111;

  function automatic int budget(input int unsigned p);
    return (p == 0) ? 1 : int'(p);
  endfunction

  task automatic enter(input int mode);
    m_mode  = mode;
    m_ticks = 0;
  endtask

  task automatic model_edge(input bit rst, input logic [5:0] pins);
    bit en, srn, act, bg_n, idle, abort;
    if (rst) begin
      m_mode = 0; m_ticks = 0; m_tmo = 0;
      seen_lag0 = 6'b010111; seen_lag1 = 6'b010111;
      return;
    end
    {en, srn, act, bg_n} = seen_lag1[5:2];
    idle  = seen_lag1[1] && seen_lag1[0];
    seen_lag1 = seen_lag0;
    seen_lag0 = pins;
    abort = !srn || !en;
    case (m_mode)
      0: if (en && srn) enter(1);
      1: if (abort) enter(5);
         else if (act) enter(2);
         else begin m_ticks++; if (m_ticks >= budget(ALIVE)) enter(6); end
      2: if (abort) enter(5);
         else if (!bg_n && idle) enter(3);
         else begin
           m_ticks++;
           if (m_ticks >= budget(GRANT)) begin enter(6); if (m_tmo < 15) m_tmo++; end
         end
      3: if (abort) enter(5);
         else if (!idle || bg_n) m_ticks = 0;
         else begin m_ticks++; if (m_ticks >= budget(SETTLE)) enter(4); end
      4: if (abort) enter(5);
      5: if (srn) begin m_ticks++; if (m_ticks >= 2) enter(0); end
         else m_ticks = 0;
      6: if (!srn) enter(0);
      default: enter(0);
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st  = 3'(m_mode);
    e.req = (m_mode == 2) || (m_mode == 3) || (m_mode == 4);
    e.gnt = (m_mode == 4);
    e.fb  = (m_mode == 6);
    e.tmo = 4'(m_tmo);
    return e;
  endfunction

  // One E tick of stimulus, driven at the falling edge; a rising rst is checked asynchronously.
  task automatic tick(input bit r, input bit e, input bit s, input bit a,
                      input bit g, input bit as_, input bit d);
    @(negedge e_clock);
    {pistorm_en, sys_reset_n, pi_activity, m68k_bg_n, m68k_as_n, m68k_dtack_n} = {e, s, a, g, as_, d};
    if (r && !rst_pistorm_mode) begin
      rst_pistorm_mode = 1'b1;
      #1;
      chk("async_rst_request", int'(bus_request), 0);
      chk("async_rst_granted", int'(bus_granted), 0);
      chk("async_rst_state", int'(state), 0);
    end
    rst_pistorm_mode = r;
    model_edge(r, {e, s, a, g, as_, d});
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input bit e, input bit s, input bit a,
                     input bit g, input bit as_, input bit d);
    for (int i = 0; i < n; i++) tick(1'b0, e, s, a, g, as_, d);
  endtask

  task automatic handover_after_idle();
    run(4, 1, 1, 0, 0, 1, 1);
    run(1, 1, 1, 1, 0, 1, 1);
    run(10, 1, 1, 0, 0, 1, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge e_clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(state), int'(e.st));
        chk("bus_request", int'(bus_request), int'(e.req));
        chk("bus_granted", int'(bus_granted), int'(e.gnt));
        chk("fallback", int'(fallback), int'(e.fb));
        chk("timeout_count", int'(timeout_count), int'(e.tmo));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) tick(1'b1, 1, 0, 0, 1, 1, 1);
    run(3, 1, 0, 0, 1, 1, 1);

    // Normal handover, then abort via system reset and a repeat handover
    handover_after_idle();
    chk("first_handover_state", int'(state), 4);
    chk("first_handover_granted", int'(bus_granted), 1);
    run(3, 1, 0, 0, 0, 1, 1);
    run(6, 1, 1, 0, 0, 1, 1);
    run(1, 1, 1, 1, 0, 1, 1);
    run(10, 1, 1, 0, 0, 1, 1);
    chk("second_handover_state", int'(state), 4);

    // Disable in OWNED, then no Pi activity leads to fallback, cleared by a reset pulse
    run(3, 0, 1, 0, 0, 1, 1);
    run(16, 1, 1, 0, 0, 1, 1);
    chk("no_activity_fallback", int'(fallback), 1);
    chk("no_activity_no_request", int'(bus_request), 0);
    run(4, 1, 0, 0, 0, 1, 1);
    chk("fallback_cleared", int'(fallback), 0);

    // Grant never arrives: 17 timeouts saturate the tally
    for (int k = 0; k < 17; k++) begin
      run(3, 1, 0, 0, 1, 1, 1);
      run(4, 1, 1, 0, 1, 1, 1);
      run(1, 1, 1, 1, 1, 1, 1);
      run(10, 1, 1, 0, 1, 1, 1);
    end
    chk("timeout_saturated", int'(timeout_count), 15);

    // Address strobe chatter during SETTLE keeps restarting the window
    run(3, 1, 0, 0, 1, 1, 1);
    run(4, 1, 1, 0, 1, 1, 1);
    run(1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 12; i++) tick(1'b0, 1, 1, 0, 0, i[0], 1);
    chk("settle_held_by_as", int'(state), 3);
    run(5, 1, 1, 0, 0, 1, 1);
    chk("settle_then_owned", int'(state), 4);

    // Asynchronous reset while OWNED
    for (int i = 0; i < 3; i++) tick(1'b1, 1, 1, 0, 0, 1, 1);
    run(3, 1, 0, 0, 1, 1, 1);

    // Randomized traffic, occasional rst pulses
    for (int i = 0; i < 800; i++) begin
      tick(($urandom % 200) == 0, ($urandom % 16) != 0, ($urandom % 12) != 0,
           ($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 5) != 0, ($urandom % 7) != 0);
    end
    run(3, 1, 1, 0, 1, 1, 1);
    @(posedge e_clock);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
